// File: rtl/apb_rr_arbiter.sv
// rtl/apb_rr_arbiter.sv - round-robin arbiter sharing one APB master port between NUM_REQ requesters
module apb_rr_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int APB_ADDR_WIDTH = 12,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                                clk_i,
    input  logic                                rst_n,
    input  logic [NUM_REQ-1:0]                  req_i,
    input  logic [NUM_REQ-1:0]                  we_i,
    input  logic [NUM_REQ*APB_ADDR_WIDTH-1:0]   addr_i,
    input  logic [NUM_REQ*32-1:0]               wdata_i,
    output logic [NUM_REQ-1:0]                  ack_o,
    output logic [31:0]                         rdata_o,
    output logic                                err_o,
    output logic                                psel_o,
    output logic                                penable_o,
    output logic                                pwrite_o,
    output logic [APB_ADDR_WIDTH-1:0]           paddr_o,
    output logic [31:0]                         pwdata_o,
    input  logic [31:0]                         prdata_i,
    input  logic                                pready_i,
    input  logic                                pslverr_i
);

    localparam int IW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WD_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int WD_W   = (WD_RAW < 8) ? 8 : ((WD_RAW > 16) ? 16 : WD_RAW);

    // Watchdog value seen in the last permitted ACCESS cycle.
    localparam logic [WD_W-1:0] WD_LAST   = (TIMEOUT_CYCLES == 0) ? '0 : WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_MAX    = '1;
    localparam logic [IW:0]     NUM_REQ_W = (IW + 1)'(NUM_REQ);
    localparam logic [IW-1:0]   LAST_IDX  = IW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS
    } state_t;

    state_t                    state_q;
    logic [IW-1:0]             ptr_q;
    logic [WD_W-1:0]           wdog_q;
    logic [NUM_REQ-1:0]        grant_q;
    logic                      we_q;
    logic [APB_ADDR_WIDTH-1:0] addr_q;
    logic [31:0]               wdata_q;
    logic                      psel_q;
    logic                      penable_q;

    logic [IW:0]               cand;
    logic [IW-1:0]             win_idx;
    logic                      win_found;
    logic [IW-1:0]             next_ptr;
    logic [NUM_REQ-1:0]        win_oh;
    logic                      in_access;
    logic                      timeout_hit;
    logic                      done;

    // Round-robin search: walk requesters upward from ptr, wrapping at NUM_REQ.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr_q} + (IW + 1)'(k);
            if (cand >= NUM_REQ_W) begin
                cand = cand - NUM_REQ_W;
            end
            if (!win_found && req_i[cand[IW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IW-1:0];
            end
        end
    end

    assign next_ptr = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
    assign win_oh   = {{(NUM_REQ - 1){1'b0}}, 1'b1} << win_idx;

    // Completion is decided combinationally from the slave response in the ACCESS cycle.
    assign in_access   = (state_q == ST_ACCESS);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wdog_q == WD_LAST);
    assign done        = in_access && (pready_i || timeout_hit);

    assign ack_o   = done ? grant_q : '0;
    assign rdata_o = (in_access && pready_i && !we_q) ? prdata_i : 32'h0;
    assign err_o   = in_access && (pready_i ? pslverr_i : timeout_hit);

    assign psel_o    = psel_q;
    assign penable_o = penable_q;
    assign pwrite_o  = we_q;
    assign paddr_o   = addr_q;
    assign pwdata_o  = wdata_q;

    // Transfer sequencer: grant and latch in IDLE, then SETUP and ACCESS phases with watchdog.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            wdog_q    <= '0;
            grant_q   <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (win_found) begin
                        grant_q <= win_oh;
                        we_q    <= we_i[win_idx];
                        addr_q  <= addr_i[win_idx*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
                        wdata_q <= wdata_i[win_idx*32 +: 32];
                        ptr_q   <= next_ptr;
                        wdog_q  <= '0;
                        psel_q  <= 1'b1;
                        state_q <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (done) begin
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end else if (wdog_q != WD_MAX) begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                default: begin
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// tb/tb_apb_rr_arbiter.sv - self-checking bench for apb_rr_arbiter with transaction-level model
module tb_apb_rr_arbiter;

    localparam int N  = 3;
    localparam int AW = 12;
    localparam int T  = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N-1:0]    we;
    logic [N*AW-1:0] addr;
    logic [N*32-1:0] wdata;
    logic [N-1:0]    ack;
    logic [31:0]     rdata;
    logic            err;
    logic            psel;
    logic            penable;
    logic            pwrite;
    logic [AW-1:0]   paddr;
    logic [31:0]     pwdata;
    logic [31:0]     prdata;
    logic            pready;
    logic            pslverr;

    int errors = 0;
    int checks = 0;
    bit running = 1'b1;
    logic [N-1:0] ack_seen = '0;

    // Transaction model: one outstanding transfer, its age in cycles since grant.
    bit            m_busy;
    int            m_age;
    int            m_idx;
    int            m_ptr;
    int            m_j;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_wdata;
    logic [N-1:0]  e_ack;
    logic [31:0]   e_rdata;
    logic          e_err;
    logic          e_psel;
    logic          e_pen;
    logic          e_done;

    always #5 clk = ~clk;

    apb_rr_arbiter #(
        .NUM_REQ       (N),
        .APB_ADDR_WIDTH(AW),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk_i    (clk),
        .rst_n    (rst_n),
        .req_i    (req),
        .we_i     (we),
        .addr_i   (addr),
        .wdata_i  (wdata),
        .ack_o    (ack),
        .rdata_o  (rdata),
        .err_o    (err),
        .psel_o   (psel),
        .penable_o(penable),
        .pwrite_o (pwrite),
        .paddr_o  (paddr),
        .pwdata_o (pwdata),
        .prdata_i (prdata),
        .pready_i (pready),
        .pslverr_i(pslverr)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Per-cycle comparison of the DUT against the transaction model.
    initial begin
        m_busy = 1'b0;
        m_age  = 0;
        m_idx  = 0;
        m_ptr  = 0;
        forever begin
            @(negedge clk);
            if (running) begin
                if (!rst_n) begin
                    chk("rst_psel", {63'd0, psel}, 64'd0);
                    chk("rst_penable", {63'd0, penable}, 64'd0);
                    chk("rst_ack", {61'd0, ack}, 64'd0);
                    chk("rst_rdata", {32'd0, rdata}, 64'd0);
                    chk("rst_err", {63'd0, err}, 64'd0);
                    chk("rst_paddr", {52'd0, paddr}, 64'd0);
                    chk("rst_pwdata", {32'd0, pwdata}, 64'd0);
                    chk("rst_pwrite", {63'd0, pwrite}, 64'd0);
                    m_busy   = 1'b0;
                    m_ptr    = 0;
                    ack_seen = '0;
                end else begin
                    e_psel  = m_busy && (m_age >= 1);
                    e_pen   = m_busy && (m_age >= 2);
                    e_done  = e_pen && (pready || (T != 0 && (m_age - 1) == T));
                    e_ack   = '0;
                    if (e_done) e_ack[m_idx] = 1'b1;
                    e_rdata = (e_done && pready && !m_we) ? prdata : 32'h0;
                    e_err   = e_done && (pready ? pslverr : 1'b1);
                    chk("cmp_psel", {63'd0, psel}, {63'd0, e_psel});
                    chk("cmp_penable", {63'd0, penable}, {63'd0, e_pen});
                    chk("cmp_ack", {61'd0, ack}, {61'd0, e_ack});
                    chk("cmp_rdata", {32'd0, rdata}, {32'd0, e_rdata});
                    chk("cmp_err", {63'd0, err}, {63'd0, e_err});
                    if (e_psel) begin
                        chk("cmp_pwrite", {63'd0, pwrite}, {63'd0, m_we});
                        chk("cmp_paddr", {52'd0, paddr}, {52'd0, m_addr});
                        chk("cmp_pwdata", {32'd0, pwdata}, {32'd0, m_wdata});
                    end
                    ack_seen = ack;
                    if (!m_busy) begin
                        for (int k = 0; k < N; k++) begin
                            m_j = (m_ptr + k) % N;
                            if (!m_busy && req[m_j]) begin
                                m_busy  = 1'b1;
                                m_idx   = m_j;
                                m_age   = 1;
                                m_we    = we[m_j];
                                m_addr  = addr[m_j*AW +: AW];
                                m_wdata = wdata[m_j*32 +: 32];
                                m_ptr   = (m_j + 1) % N;
                            end
                        end
                    end else if (e_done) begin
                        m_busy = 1'b0;
                    end else begin
                        m_age++;
                    end
                end
            end
        end
    end

    // Directed scenarios with literal expectations, then randomized traffic.
    initial begin
        logic [N-1:0] e;
        logic [31:0]  rnd;
        int           stall;
        rst_n   = 1'b0;
        req     = '0;
        we      = '0;
        addr    = '0;
        wdata   = '0;
        prdata  = '0;
        pready  = 1'b0;
        pslverr = 1'b0;
        stall   = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_psel", {63'd0, psel}, 64'd0);
        chk("reset_ack", {61'd0, ack}, 64'd0);
        rst_n  = 1'b1;
        pready = 1'b1;

        // Round-robin with both requests held: grants 0,1,0,1, 3 cycles each.
        tick;
        req = 3'b011;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            e = (c % 3 == 2) ? (((c / 3) % 2 == 0) ? 3'b001 : 3'b010) : 3'b000;
            chk($sformatf("rr_ack_c%0d", c), {61'd0, ack}, {61'd0, e});
            tick;
        end
        req = '0;

        // Single read with immediate PREADY.
        tick;
        we             = '0;
        addr[0 +: AW]  = 12'h008;
        prdata         = 32'hDEADBEEF;
        pslverr        = 1'b0;
        pready         = 1'b1;
        req            = 3'b001;
        @(negedge clk);
        chk("sr_psel_c0", {63'd0, psel}, 64'd0);
        tick;
        @(negedge clk);
        chk("sr_psel_c1", {63'd0, psel}, 64'd1);
        chk("sr_penable_c1", {63'd0, penable}, 64'd0);
        chk("sr_paddr_c1", {52'd0, paddr}, 64'h008);
        tick;
        @(negedge clk);
        chk("sr_penable_c2", {63'd0, penable}, 64'd1);
        chk("sr_ack_c2", {61'd0, ack}, 64'd1);
        chk("sr_rdata_c2", {32'd0, rdata}, 64'hDEADBEEF);
        chk("sr_err_c2", {63'd0, err}, 64'd0);
        tick;
        req = '0;

        // Write with 5 wait states then PSLVERR; requester inputs altered during SETUP.
        tick;
        req              = 3'b010;
        we               = 3'b010;
        addr[AW +: AW]   = 12'h0AC;
        wdata[32 +: 32]  = 32'h12345678;
        pready           = 1'b0;
        pslverr          = 1'b0;
        prdata           = 32'hCAFEF00D;
        for (int c = 0; c < 8; c++) begin
            if (c == 1) begin
                addr[AW +: AW]  = 12'hFFF;
                wdata[32 +: 32] = 32'h0BADC0DE;
            end
            if (c == 7) begin
                pready  = 1'b1;
                pslverr = 1'b1;
            end
            @(negedge clk);
            if (c >= 1) begin
                chk($sformatf("ws_paddr_c%0d", c), {52'd0, paddr}, 64'h0AC);
                chk($sformatf("ws_pwdata_c%0d", c), {32'd0, pwdata}, 64'h12345678);
                chk($sformatf("ws_pwrite_c%0d", c), {63'd0, pwrite}, 64'd1);
            end
            if (c >= 2) begin
                e = (c == 7) ? 3'b010 : 3'b000;
                chk($sformatf("ws_ack_c%0d", c), {61'd0, ack}, {61'd0, e});
            end
            if (c == 7) begin
                chk("ws_err", {63'd0, err}, 64'd1);
                chk("ws_rdata", {32'd0, rdata}, 64'd0);
            end
            tick;
        end
        req     = '0;
        pready  = 1'b0;
        pslverr = 1'b0;

        // Watchdog: stuck slave times out after T ACCESS cycles, queued request then served.
        tick;
        req    = 3'b001;
        we     = '0;
        prdata = 32'h55AA55AA;
        pready = 1'b0;
        for (int c = 0; c < 13; c++) begin
            if (c == 1) req[2] = 1'b1;
            if (c == 10) begin
                req[0] = 1'b0;
                pready = 1'b1;
                prdata = 32'h00001234;
            end
            @(negedge clk);
            e = (c == 9) ? 3'b001 : ((c == 12) ? 3'b100 : 3'b000);
            chk($sformatf("to_ack_c%0d", c), {61'd0, ack}, {61'd0, e});
            if (c == 9) begin
                chk("to_err", {63'd0, err}, 64'd1);
                chk("to_rdata", {32'd0, rdata}, 64'd0);
            end
            if (c == 12) begin
                chk("to_next_err", {63'd0, err}, 64'd0);
                chk("to_next_rdata", {32'd0, rdata}, 64'h1234);
            end
            tick;
        end
        req    = '0;
        pready = 1'b0;

        // Asynchronous reset in the middle of ACCESS.
        tick;
        req = 3'b001;
        @(negedge clk);
        tick;
        @(negedge clk);
        tick;
        @(negedge clk);
        chk("ar_psel_before", {63'd0, psel}, 64'd1);
        chk("ar_penable_before", {63'd0, penable}, 64'd1);
        #2;
        rst_n = 1'b0;
        req   = '0;
        #1;
        chk("ar_psel_async", {63'd0, psel}, 64'd0);
        chk("ar_penable_async", {63'd0, penable}, 64'd0);
        chk("ar_ack_async", {61'd0, ack}, 64'd0);
        repeat (2) tick;
        tick;
        rst_n  = 1'b1;
        req    = 3'b010;
        pready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            e = (c == 2) ? 3'b010 : 3'b000;
            chk($sformatf("ar_ack_c%0d", c), {61'd0, ack}, {61'd0, e});
            tick;
        end
        req = '0;

        // Randomized traffic against the model.
        tick;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (req[i] && ack_seen[i]) begin
                    req[i] = 1'b0;
                end else if (req[i] && $urandom_range(0, 99) == 0) begin
                    req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                    we[i]  = ($urandom_range(0, 1) == 1);
                    rnd    = $urandom;
                    addr[i*AW +: AW] = rnd[AW-1:0];
                    wdata[i*32 +: 32] = $urandom;
                end
                if ($urandom_range(0, 7) == 0) begin
                    rnd = $urandom;
                    addr[i*AW +: AW] = rnd[AW-1:0];
                    wdata[i*32 +: 32] = $urandom;
                end
            end
            if (stall > 0) begin
                pready = 1'b0;
                stall--;
            end else if ($urandom_range(0, 39) == 0) begin
                stall  = int'($urandom_range(5, 12));
                pready = 1'b0;
            end else begin
                pready = ($urandom_range(0, 3) != 0);
            end
            prdata  = $urandom;
            pslverr = ($urandom_range(0, 7) == 0);
            @(negedge clk);
            tick;
        end

        running = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
